// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes opcodes into registered ALU control fields and
// sequences a shift-add multiply. Optional multiply support: define ALU_CTRL_MUL_EN.
module alu_ctrl_seq #(
  parameter int WIDTH = 8,
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [4:0]    opcode,
  input  logic          hold,
  output logic [3:0]    compare_ctrl,
  output logic [1:0]    andornot_ctrl,
  output logic          addsub_ctrl,
  output logic [1:0]    mux_ctrl,
  output logic          ctrl_valid,
  output logic          acc_clr,
  output logic          acc_shift,
  output logic [SW-1:0] step,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_STEP = 2'd2
  } state_t;

`ifdef ALU_CTRL_MUL_EN
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);
`endif

  state_t        state_q, state_nx;
  logic [SW-1:0] step_q, step_nx;
  logic [3:0]    cmp_nx;
  logic [1:0]    aon_nx;
  logic          as_nx;
  logic [1:0]    mux_nx;
  logic          cv_nx;
  logic          clr_nx;
  logic          sh_nx;
  logic          done_nx;
  logic          err_nx;
  logic          accept;

  // Ready is combinational on hold so a stall takes effect in the same cycle.
  assign op_ready = !rst && !hold && ((state_q == S_IDLE)
`ifdef ALU_CTRL_MUL_EN
                    || ((state_q == S_STEP) && (step_q == LAST))
`endif
                    );
  assign accept = op_valid && op_ready;
  assign step   = step_q;

  // Next-state and next-output decode; hold keeps every register unchanged.
  always_comb begin
    state_nx = state_q;
    step_nx  = step_q;
    cmp_nx   = compare_ctrl;
    aon_nx   = andornot_ctrl;
    as_nx    = addsub_ctrl;
    mux_nx   = mux_ctrl;
    cv_nx    = ctrl_valid;
    clr_nx   = acc_clr;
    sh_nx    = acc_shift;
    done_nx  = done;
    err_nx   = err;
    if (hold) begin
      state_nx = state_q;
    end else begin
      state_nx = S_IDLE;
      step_nx  = '0;
      cmp_nx   = 4'd0;
      aon_nx   = 2'b11;
      as_nx    = 1'b0;
      mux_nx   = 2'b00;
      cv_nx    = 1'b0;
      clr_nx   = 1'b0;
      sh_nx    = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      if (accept) begin
        cv_nx   = 1'b1;
        done_nx = 1'b1;
        case (opcode)
          5'h00: cmp_nx = 4'd2;
          5'h01: cmp_nx = 4'd3;
          5'h04: cmp_nx = 4'd4;
          5'h05: cmp_nx = 4'd5;
          5'h09: cmp_nx = 4'd6;
          5'h0A: cmp_nx = 4'd7;
          5'h0B: cmp_nx = 4'd8;
          5'h0C: cmp_nx = 4'd9;
          5'h0D: cmp_nx = 4'd10;
          5'h0E: cmp_nx = 4'd11;
          5'h02: begin as_nx = 1'b0; mux_nx = 2'b10; end
          5'h03: begin as_nx = 1'b1; mux_nx = 2'b10; end
          5'h06: begin aon_nx = 2'b00; mux_nx = 2'b01; end
          5'h07: begin aon_nx = 2'b11; mux_nx = 2'b01; end
          5'h08: begin aon_nx = 2'b01; mux_nx = 2'b01; end
          5'h0F: begin aon_nx = 2'b10; mux_nx = 2'b01; end
`ifdef ALU_CTRL_MUL_EN
          5'h10: begin
            state_nx = S_CLR;
            clr_nx   = 1'b1;
            mux_nx   = 2'b11;
            done_nx  = 1'b0;
          end
`endif
          default: begin
            cv_nx   = 1'b0;
            done_nx = 1'b0;
            err_nx  = 1'b1;
          end
        endcase
`ifdef ALU_CTRL_MUL_EN
      end else if (state_q == S_CLR) begin
        state_nx = S_STEP;
        step_nx  = '0;
        cv_nx    = 1'b1;
        sh_nx    = 1'b1;
        mux_nx   = 2'b11;
      end else if ((state_q == S_STEP) && (step_q != LAST)) begin
        state_nx = S_STEP;
        step_nx  = step_q + SW'(1);
        cv_nx    = 1'b1;
        sh_nx    = 1'b1;
        mux_nx   = 2'b11;
        done_nx  = (step_nx == LAST);
`endif
      end else begin
        state_nx = S_IDLE;
      end
    end
  end

  // State and output registers with synchronous reset to idle defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      compare_ctrl  <= 4'd0;
      andornot_ctrl <= 2'b11;
      addsub_ctrl   <= 1'b0;
      mux_ctrl      <= 2'b00;
      ctrl_valid    <= 1'b0;
      acc_clr       <= 1'b0;
      acc_shift     <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_nx;
      step_q        <= step_nx;
      compare_ctrl  <= cmp_nx;
      andornot_ctrl <= aon_nx;
      addsub_ctrl   <= as_nx;
      mux_ctrl      <= mux_nx;
      ctrl_valid    <= cv_nx;
      acc_clr       <= clr_nx;
      acc_shift     <= sh_nx;
      done          <= done_nx;
      err           <= err_nx;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq (WIDTH=8); multiply checks follow ALU_CTRL_MUL_EN.
module tb_alu_ctrl_seq;
  localparam int WIDTH = 8;
  localparam int SW = 3;

  logic          clk;
  logic          rst;
  logic          op_valid;
  logic          op_ready;
  logic [4:0]    opcode;
  logic          hold;
  logic [3:0]    compare_ctrl;
  logic [1:0]    andornot_ctrl;
  logic          addsub_ctrl;
  logic [1:0]    mux_ctrl;
  logic          ctrl_valid;
  logic          acc_clr;
  logic          acc_shift;
  logic [SW-1:0] step;
  logic          done;
  logic          err;

  int total = 0;
  int bad = 0;

  alu_ctrl_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .hold(hold), .compare_ctrl(compare_ctrl),
    .andornot_ctrl(andornot_ctrl), .addsub_ctrl(addsub_ctrl),
    .mux_ctrl(mux_ctrl), .ctrl_valid(ctrl_valid), .acc_clr(acc_clr),
    .acc_shift(acc_shift), .step(step), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full output vector: {compare, andornot, addsub, mux, valid, clr, shift, step, done, err}
  task automatic check_out(input string tag, input logic [3:0] c, input logic [1:0] a,
                           input logic s, input logic [1:0] m, input logic v,
                           input logic cl, input logic sh, input logic [SW-1:0] st,
                           input logic d, input logic e);
    check(tag, {16'd0, compare_ctrl, andornot_ctrl, addsub_ctrl, mux_ctrl, ctrl_valid,
                acc_clr, acc_shift, step, done, err},
               {16'd0, c, a, s, m, v, cl, sh, st, d, e});
  endtask

  task automatic single(input logic [4:0] op, input logic [3:0] c, input logic [1:0] a,
                        input logic s, input logic [1:0] m);
    opcode = op;
    cyc();
    check_out($sformatf("op%02h", op), c, a, s, m, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; opcode = 5'd0; hold = 1'b0;
    cyc(); cyc();
    check("rdy_in_rst", {31'd0, op_ready}, 32'd0);
    check_out("reset", 4'd0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", {31'd0, op_ready}, 32'd1);

    // back-to-back single-cycle ops at full rate
    op_valid = 1'b1;
    single(5'h00, 4'd2,  2'b11, 1'b0, 2'b00);
    single(5'h03, 4'd0,  2'b11, 1'b1, 2'b10);
    single(5'h07, 4'd0,  2'b11, 1'b0, 2'b01);
    single(5'h0E, 4'd11, 2'b11, 1'b0, 2'b00);
    single(5'h0F, 4'd0,  2'b10, 1'b0, 2'b01);
    single(5'h06, 4'd0,  2'b00, 1'b0, 2'b01);
    single(5'h05, 4'd5,  2'b11, 1'b0, 2'b00);
    single(5'h08, 4'd0,  2'b01, 1'b0, 2'b01);
    single(5'h09, 4'd6,  2'b11, 1'b0, 2'b00);
    single(5'h02, 4'd0,  2'b11, 1'b0, 2'b10);
    op_valid = 1'b0;
    cyc();
    check_out("idle_after", 4'd0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // illegal opcode
    op_valid = 1'b1; opcode = 5'h15;
    cyc();
    check_out("illegal15", 4'd0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    op_valid = 1'b0;
    cyc();
    check("err_pulse", {31'd0, err}, 32'd0);

    // opcode ignored without op_valid
    opcode = 5'h03;
    cyc();
    check_out("no_valid", 4'd0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // hold freezes outputs in IDLE and blocks acceptance
    op_valid = 1'b1;
    single(5'h04, 4'd4, 2'b11, 1'b0, 2'b00);
    hold = 1'b1; opcode = 5'h01;
    #1;
    check("rdy_hold", {31'd0, op_ready}, 32'd0);
    cyc(); cyc();
    check_out("hold_idle", 4'd4, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    hold = 1'b0;
    cyc();
    check_out("hold_rel", 4'd3, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    op_valid = 1'b0;
    cyc();

`ifdef ALU_CTRL_MUL_EN
    // multiply, with op 0x02 offered continuously behind it
    op_valid = 1'b1; opcode = 5'h10;
    cyc();
    check_out("mul_clr", 4'd0, 2'b11, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check("rdy_clr", {31'd0, op_ready}, 32'd0);
    opcode = 5'h02;
    for (int k = 0; k < WIDTH; k++) begin
      cyc();
      check_out($sformatf("mul_step%0d", k), 4'd0, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1,
                k[SW-1:0], (k == WIDTH - 1), 1'b0);
      check($sformatf("rdy_step%0d", k), {31'd0, op_ready}, (k == WIDTH - 1) ? 32'd1 : 32'd0);
    end
    cyc();
    check_out("add_after_mul", 4'd0, 2'b11, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    op_valid = 1'b0;
    cyc();

    // hold at step 4, then reset mid-STEP
    op_valid = 1'b1; opcode = 5'h10;
    cyc();
    op_valid = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    check("step4", {29'd0, step}, 32'd4);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_out($sformatf("hold_step%0d", k), 4'd0, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1,
                3'd4, 1'b0, 1'b0);
    end
    rst = 1'b1;
    cyc();
    check_out("rst_mid_step", 4'd0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0; hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check($sformatf("no_done%0d", k), {30'd0, done, err}, 32'd0);
    end
`else
    // multiply disabled: 0x10 is illegal
    op_valid = 1'b1; opcode = 5'h10;
    cyc();
    check_out("mul_illegal", 4'd0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("rdy_no_mul", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("no_acc%0d", k), {29'd0, acc_clr, acc_shift, err}, 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter: WIDTH, default 8, ALU datapath width (legal >=2); sets MUL step count; SW = clog2(WIDTH).
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: op_valid  input  1  opcode offered.
REQ-005 Port: op_ready  output  1  block accepts opcode this cycle; transfer = op_valid&&op_ready.
REQ-006 Port: opcode  input  5  operation code.
REQ-007 Port: hold  input  1  downstream stall; freezes block.
REQ-008 Port: compare_ctrl  output  4  compare-unit select.
REQ-009 Port: andornot_ctrl  output  2  logic-unit select.
REQ-010 Port: addsub_ctrl  output  1  0 add, 1 subtract.
REQ-011 Port: mux_ctrl  output  2  result select: 00 compare, 01 logic, 10 add/sub, 11 accumulator.
REQ-012 Port: ctrl_valid  output  1  control outputs meaningful this cycle.
REQ-013 Port: acc_clr  output  1  clear accumulator (MUL first cycle).
REQ-014 Port: acc_shift  output  1  add-and-shift accumulator step.
REQ-015 Port: step  output  SW  current MUL step index.
REQ-016 Port: done  output  1  one-cycle pulse, operation complete.
REQ-017 Port: err  output  1  one-cycle pulse, illegal opcode accepted.

Function
REQ-018 All outputs SHALL be registered; idle defaults: compare_ctrl 0, andornot_ctrl 11, addsub_ctrl 0, mux_ctrl 00, all 1-bit outputs 0, step 0.
REQ-019 Every cycle with ctrl_valid=1, control fields not used by the operation SHALL carry idle defaults (no stale values).
REQ-020 Single-cycle map: op 0x00/01/04/05 -> compare 2/3/4/5; 0x09..0x0E -> compare 6..11; mux 00.
REQ-021 Op 0x02 -> addsub 0, 0x03 -> addsub 1; mux 10.
REQ-022 Op 0x06 -> andornot 00, 0x07 -> 11, 0x08 -> 01, 0x0F -> 10; mux 01.
REQ-023 Single-cycle op accepted at cycle N SHALL drive its controls with ctrl_valid=1 and done=1 in cycle N+1 only; back-to-back acceptance at full rate SHALL be supported.
REQ-024 FSM states IDLE, CLR, STEP; single-cycle ops never leave IDLE.
REQ-025 MUL (0x10) accepted in IDLE SHALL go to CLR: next cycle ctrl_valid=1, acc_clr=1, mux 11.
REQ-026 CLR -> STEP for exactly WIDTH cycles: ctrl_valid=1, acc_shift=1, addsub 0, mux 11, step 0..WIDTH-1 incrementing.
REQ-027 done=1 on the step=WIDTH-1 cycle; STEP -> IDLE (or CLR if a new MUL is accepted that cycle).
REQ-028 op_ready = !hold && (state==IDLE || (state==STEP && step==WIDTH-1)).
REQ-029 Opcodes 0x11..0x1F SHALL be accepted, yield err=1 in N+1, ctrl_valid=0, done=0, idle defaults.
REQ-030 hold=1 SHALL freeze state, step and all outputs (pulses repeat, not re-issued); release resumes exactly.
REQ-031 opcode SHALL be ignored when op_valid=0 or op_ready=0.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, step 0, all outputs to REQ-018 defaults; reset overrides hold.
REQ-033 Reset during CLR/STEP SHALL abort MUL without done or err.
REQ-034 op_ready SHALL be 0 while rst=1 and 1 on the first cycle after release (hold=0).

Configuration
REQ-035 Macro ALU_CTRL_MUL_EN: defined -> MUL per REQ-025..027; undefined -> 0x10 is illegal per REQ-029, CLR/STEP absent, acc_clr, acc_shift, step tied 0.

Verification
REQ-036 Reset, then op 0x00,0x03,0x07 back-to-back -> compare 2/mux 00, addsub 1/mux 10, andornot 11/mux 01 in consecutive cycles, done each cycle.
REQ-037 WIDTH=8, MUL -> 1 acc_clr cycle, 8 acc_shift cycles step 0..7, done on step 7, op_ready low for 8 cycles.
REQ-038 MUL then op 0x02 offered continuously -> 0x02 accepted on step 7, add controls the following cycle.
REQ-039 Op 0x15 -> err=1 one cycle, ctrl_valid 0, done 0.
REQ-040 hold=1 for 3 cycles at step 4, then rst mid-STEP -> step frozen at 4, then all defaults, no done.
REQ-041 Build without ALU_CTRL_MUL_EN, op 0x10 -> err=1, acc_clr/acc_shift never asserted.
